// File: rtl/axi_axis_writer_fifo.sv
// AXI4-Lite slave that turns register writes into AXI-Stream beats through a FWFT FIFO.
// Offset 0x0/0x4 push data (0x4 marks tlast), 0x8 is status with W1C overflow, 0xC is undecoded.
module axi_axis_writer_fifo #(
    parameter int AXI_DATA_WIDTH  = 32,
    parameter int AXI_ADDR_WIDTH  = 16,
    parameter int AXIS_DATA_WIDTH = 24,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [AXI_ADDR_WIDTH-1:0]  s_axi_awaddr,
    input  logic                       s_axi_awvalid,
    output logic                       s_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]  s_axi_wdata,
    input  logic                       s_axi_wvalid,
    output logic                       s_axi_wready,
    output logic [1:0]                 s_axi_bresp,
    output logic                       s_axi_bvalid,
    input  logic                       s_axi_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]  s_axi_araddr,
    input  logic                       s_axi_arvalid,
    output logic                       s_axi_arready,
    output logic [AXI_DATA_WIDTH-1:0]  s_axi_rdata,
    output logic [1:0]                 s_axi_rresp,
    output logic                       s_axi_rvalid,
    input  logic                       s_axi_rready,
    output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] SEL_STATUS  = 2'd2;

    logic                      aw_held;
    logic                      w_held;
    logic [1:0]                aw_sel;
    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [PW-1:0]             wr_ptr;
    logic [PW-1:0]             rd_ptr;
    logic [CW-1:0]             count;
    logic                      overflow;
    logic [AXIS_DATA_WIDTH:0]  mem [FIFO_DEPTH];
    logic [AXIS_DATA_WIDTH:0]  head;
    logic [AXIS_DATA_WIDTH-1:0] push_data;
    logic [AXI_DATA_WIDTH-1:0] status;
    logic full, empty, commit, to_fifo, push, pop;
    logic unused_bits;

    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign commit  = aw_held & w_held;
    assign to_fifo = ~aw_sel[1];
    // A full FIFO rejects the push even if a pop happens on the same edge.
    assign push    = commit & to_fifo & ~full;
    assign pop     = ~empty & m_axis_tready;

    assign s_axi_awready = ~aw_held & ~s_axi_bvalid;
    assign s_axi_wready  = ~w_held & ~s_axi_bvalid;
    assign s_axi_arready = ~s_axi_rvalid;

    generate
        if (AXIS_DATA_WIDTH <= AXI_DATA_WIDTH) begin : g_trunc
            assign push_data = w_data[AXIS_DATA_WIDTH-1:0];
        end else begin : g_zext
            assign push_data = {{(AXIS_DATA_WIDTH-AXI_DATA_WIDTH){1'b0}}, w_data};
        end
    endgenerate

    assign head          = mem[rd_ptr];
    assign m_axis_tdata  = head[AXIS_DATA_WIDTH-1:0];
    assign m_axis_tlast  = head[AXIS_DATA_WIDTH];
    assign m_axis_tvalid = ~empty;

    always_comb begin
        status       = '0;
        status[15:0] = 16'(count);
        status[16]   = full;
        status[17]   = empty;
        status[18]   = overflow;
    end

    // Storage carries no reset so it can map onto distributed/block RAM.
    always_ff @(posedge aclk) begin
        if (push) mem[wr_ptr] <= {aw_sel[0], push_data};
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            aw_sel       <= '0;
            w_data       <= '0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= RESP_OKAY;
            s_axi_rvalid <= 1'b0;
            s_axi_rresp  <= RESP_OKAY;
            s_axi_rdata  <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow     <= 1'b0;
        end else begin
            if (s_axi_awvalid && s_axi_awready) begin
                aw_held <= 1'b1;
                aw_sel  <= s_axi_awaddr[3:2];
            end
            if (s_axi_wvalid && s_axi_wready) begin
                w_held <= 1'b1;
                w_data <= s_axi_wdata;
            end

            if (commit) begin
                aw_held      <= 1'b0;
                w_held       <= 1'b0;
                s_axi_bvalid <= 1'b1;
                case (aw_sel)
                    2'd0, 2'd1: s_axi_bresp <= full ? RESP_SLVERR : RESP_OKAY;
                    SEL_STATUS: s_axi_bresp <= RESP_OKAY;
                    default:    s_axi_bresp <= RESP_DECERR;
                endcase
            end else if (s_axi_bvalid && s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end

            if (commit && to_fifo && full)
                overflow <= 1'b1;
            else if (commit && aw_sel == SEL_STATUS && w_data[18])
                overflow <= 1'b0;

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);

            if (s_axi_arvalid && s_axi_arready) begin
                s_axi_rvalid <= 1'b1;
                if (s_axi_araddr[3:2] == SEL_STATUS) begin
                    s_axi_rdata <= status;
                    s_axi_rresp <= RESP_OKAY;
                end else begin
                    s_axi_rdata <= '0;
                    s_axi_rresp <= RESP_DECERR;
                end
            end else if (s_axi_rvalid && s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end

    assign unused_bits = ^{s_axi_awaddr[AXI_ADDR_WIDTH-1:4], s_axi_awaddr[1:0],
                           s_axi_araddr[AXI_ADDR_WIDTH-1:4], s_axi_araddr[1:0], w_data};
endmodule

// File: tb/tb_axi_axis_writer_fifo.sv
// Bench for axi_axis_writer_fifo: directed steps plus randomized pushes under random
// backpressure, checked against a queue model of the FIFO and overflow flag.
module tb_axi_axis_writer_fifo;
    logic        aclk = 1'b0;
    logic        aresetn;
    logic [15:0] s_axi_awaddr;
    logic        s_axi_awvalid, s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic        s_axi_wvalid, s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid, s_axi_bready;
    logic [15:0] s_axi_araddr;
    logic        s_axi_arvalid, s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid, s_axi_rready;
    logic [23:0] m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;

    int checks = 0;
    int errors = 0;
    logic [24:0] mq[$];
    logic        ovf_m = 1'b0;
    logic        stall_prev = 1'b0;
    logic [24:0] stall_val;
    logic        rnd_on;

    always #5 aclk = ~aclk;

    axi_axis_writer_fifo #(
        .AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(16), .AXIS_DATA_WIDTH(24), .FIFO_DEPTH(16)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        return {13'b0, ovf_m, mq.size() == 0, mq.size() == 16, 16'(mq.size())};
    endfunction

    // Stream side: every accepted beat must be the oldest entry the model holds,
    // and a stalled head must not change.
    always @(negedge aclk) begin
        logic [31:0] exp;
        if (!aresetn) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && m_axis_tvalid)
                chk("tdata_stable", {7'b0, m_axis_tlast, m_axis_tdata}, {7'b0, stall_val});
            stall_prev = m_axis_tvalid && !m_axis_tready;
            stall_val  = {m_axis_tlast, m_axis_tdata};
            if (m_axis_tvalid && m_axis_tready) begin
                exp = (mq.size() > 0) ? {7'b0, mq.pop_front()} : 32'hFFFF_FFFF;
                chk("beat", {7'b0, m_axis_tlast, m_axis_tdata}, exp);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge aclk); #1; end
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [31:0] data, input string tag);
        logic ha, hw, ad, wd, got;
        logic [1:0] er, r;
        s_axi_awaddr = addr; s_axi_wdata = data;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        ad = 1'b0; wd = 1'b0;
        for (int n = 0; n < 50 && !(ad && wd); n++) begin
            @(negedge aclk);
            ha = s_axi_awvalid && s_axi_awready;
            hw = s_axi_wvalid && s_axi_wready;
            @(posedge aclk); #1;
            if (ha) begin s_axi_awvalid = 1'b0; ad = 1'b1; end
            if (hw) begin s_axi_wvalid = 1'b0; wd = 1'b1; end
        end
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        chk({tag, "_handshake"}, {31'b0, ad && wd}, 32'd1);
        case (addr[3:2])
            2'd0, 2'd1: begin
                if (mq.size() >= 16) begin er = 2'b10; ovf_m = 1'b1; end
                else begin er = 2'b00; mq.push_back({addr[2], data[23:0]}); end
            end
            2'd2: begin er = 2'b00; if (data[18]) ovf_m = 1'b0; end
            default: er = 2'b11;
        endcase
        s_axi_bready = 1'b1; got = 1'b0; r = 2'bxx;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge aclk);
            if (s_axi_bvalid) begin r = s_axi_bresp; got = 1'b1; end
            @(posedge aclk); #1;
        end
        s_axi_bready = 1'b0;
        chk({tag, "_bvalid"}, {31'b0, got}, 32'd1);
        chk({tag, "_bresp"}, {30'b0, r}, {30'b0, er});
    endtask

    task automatic do_read(input logic [15:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp, input string tag);
        logic h, done, got;
        logic [31:0] d;
        logic [1:0] r;
        s_axi_araddr = addr; s_axi_arvalid = 1'b1; done = 1'b0;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge aclk); h = s_axi_arready;
            @(posedge aclk); #1;
            if (h) begin s_axi_arvalid = 1'b0; done = 1'b1; end
        end
        s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b1; got = 1'b0; d = 'x; r = 'x;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge aclk);
            if (s_axi_rvalid) begin d = s_axi_rdata; r = s_axi_rresp; got = 1'b1; end
            @(posedge aclk); #1;
        end
        s_axi_rready = 1'b0;
        chk({tag, "_rvalid"}, {31'b0, done && got}, 32'd1);
        chk({tag, "_rdata"}, d, exp_data);
        chk({tag, "_rresp"}, {30'b0, r}, {30'b0, exp_resp});
    endtask

    task automatic drain(input string tag);
        m_axis_tready = 1'b1;
        for (int n = 0; n < 200 && mq.size() > 0; n++) begin @(posedge aclk); #1; end
        chk({tag, "_model_empty"}, mq.size(), 0);
        chk({tag, "_tvalid_low"}, {31'b0, m_axis_tvalid}, 32'd0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_awready"}, {31'b0, s_axi_awready}, 32'd1);
        chk({tag, "_wready"},  {31'b0, s_axi_wready},  32'd1);
        chk({tag, "_arready"}, {31'b0, s_axi_arready}, 32'd1);
        chk({tag, "_bvalid"},  {31'b0, s_axi_bvalid},  32'd0);
        chk({tag, "_rvalid"},  {31'b0, s_axi_rvalid},  32'd0);
        chk({tag, "_tvalid"},  {31'b0, m_axis_tvalid}, 32'd0);
    endtask

    initial begin
        aresetn = 1'b0;
        s_axi_awaddr = '0; s_axi_awvalid = 0; s_axi_wdata = '0; s_axi_wvalid = 0;
        s_axi_bready = 0; s_axi_araddr = '0; s_axi_arvalid = 0; s_axi_rready = 0;
        m_axis_tready = 0; rnd_on = 0;
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        chk_idle_outputs("reset");
        chk("reset_bresp", {30'b0, s_axi_bresp}, 32'd0);
        chk("reset_rresp", {30'b0, s_axi_rresp}, 32'd0);
        chk("reset_rdata", s_axi_rdata, 32'd0);

        // Single push, latency from concurrent AW+W handshake to tvalid.
        s_axi_awaddr = 16'h0; s_axi_wdata = 32'h00A5A5A5;
        s_axi_awvalid = 1; s_axi_wvalid = 1;
        @(posedge aclk); #1;
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        mq.push_back({1'b0, 24'hA5A5A5});
        chk("lat_e0_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
        chk("lat_e0_bvalid", {31'b0, s_axi_bvalid}, 32'd0);
        @(posedge aclk); #1;
        chk("lat_e1_tvalid", {31'b0, m_axis_tvalid}, 32'd1);
        chk("lat_e1_bvalid", {31'b0, s_axi_bvalid}, 32'd1);
        chk("lat_bresp", {30'b0, s_axi_bresp}, 32'd0);
        chk("lat_tdata", {7'b0, m_axis_tlast, m_axis_tdata}, 32'h00A5A5A5);
        s_axi_bready = 1; @(posedge aclk); #1; s_axi_bready = 0;
        chk("lat_bvalid_clr", {31'b0, s_axi_bvalid}, 32'd0);
        drain("lat");

        // Short packet: tlast only on the beat written to 0x4.
        do_write(16'h0, 32'h1, "pkt1");
        do_write(16'h0, 32'h2, "pkt2");
        do_write(16'h4, 32'h3, "pkt3");
        drain("pkt");

        // W three cycles ahead of AW, B held off for five cycles.
        m_axis_tready = 0;
        s_axi_awaddr = 16'h0; s_axi_wdata = 32'h0000_0055; s_axi_wvalid = 1;
        @(posedge aclk); #1; s_axi_wvalid = 0;
        chk("wfirst_wready", {31'b0, s_axi_wready}, 32'd0);
        chk("wfirst_awready", {31'b0, s_axi_awready}, 32'd1);
        idle(2);
        s_axi_awvalid = 1;
        @(posedge aclk); #1; s_axi_awvalid = 0;
        mq.push_back({1'b0, 24'h55});
        @(posedge aclk); #1;
        for (int i = 0; i < 5; i++) begin
            chk("bhold_bvalid", {31'b0, s_axi_bvalid}, 32'd1);
            chk("bhold_readies", {30'b0, s_axi_awready, s_axi_wready}, 32'd0);
            @(posedge aclk); #1;
        end
        s_axi_bready = 1; @(posedge aclk); #1; s_axi_bready = 0;
        do_read(16'h8, exp_status(), 2'b00, "bhold_status");
        drain("bhold");

        // Undecoded offset.
        do_read(16'hC, 32'h0, 2'b11, "rd_c");
        do_write(16'hC, 32'hDEAD_BEEF, "wr_c");
        do_read(16'h8, 32'h0002_0000, 2'b00, "wr_c_status");

        // Fill past depth with the stream stalled.
        m_axis_tready = 0;
        for (int i = 1; i <= 17; i++) do_write(16'h0, 32'(i), "fill");
        do_read(16'h8, 32'h0005_0010, 2'b00, "full_status");
        drain("ovf");
        do_read(16'h8, 32'h0006_0000, 2'b00, "ovf_status");
        do_write(16'h8, 32'h0004_0000, "w1c");
        do_read(16'h8, 32'h0002_0000, 2'b00, "w1c_status");

        // Random pushes against random backpressure.
        rnd_on = 1;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    do_write(16'($urandom_range(0, 1) * 4), $urandom, "rnd");
                    idle($urandom_range(0, 2));
                end
                rnd_on = 0;
            end
            begin
                while (rnd_on) begin
                    @(posedge aclk); #1;
                    m_axis_tready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain("rnd");
        m_axis_tready = 0;
        idle(1);
        do_read(16'h8, exp_status(), 2'b00, "rnd_status");

        // Asynchronous reset with beats buffered.
        for (int i = 0; i < 5; i++) do_write(16'h0, $urandom, "prerst");
        @(posedge aclk); #3;
        aresetn = 1'b0;
        #1;
        chk("rst_tvalid_async", {31'b0, m_axis_tvalid}, 32'd0);
        mq.delete();
        ovf_m = 1'b0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        chk_idle_outputs("rst2");
        do_read(16'h8, 32'h0002_0000, 2'b00, "rst2_status");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
